seven_segment_bank: RTL
=======================

# seven_segment_bank

Registered, parametrised multi-digit hexadecimal display driver for the DE1-SoC HEX displays and for external scanned (multiplexed) displays. It latches a packed multi-digit value on a load strobe, decodes every digit to an active-low 0–F glyph, and adds three display features: leading-zero suppression, per-digit blinking from an internal divider, and a time-multiplexed scan output. It sits between game/score logic and the board HEX pins.

## Interface
- DIGITS, 6, number of digits; legal range 1–8.
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; must be ≥ 2.
- SCAN_DIV, 50_000, clock cycles each digit is selected in scan mode; must be ≥ 2.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  packed digits; digit i = value[4i+3:4i]; digit 0 is least significant.
- load  in  1  when high at a clock edge, value is captured into the internal digit register.
- enable  in  1  0 forces all segments off; counters keep running.
- blank_lz  in  1  1 enables leading-zero suppression.
- blink_mask  in  DIGITS  bit i = 1 makes digit i blink.
- segments  out  7*DIGITS  parallel active-low segments; digit i = segments[7i+6:7i], bit order {g,f,e,d,c,b,a}.
- scan_seg  out  7  active-low segments of the currently scanned digit.
- scan_sel  out  DIGITS  active-low one-hot digit select; all ones during the inter-digit gap.

## Operation
- Glyphs are active-high {g..a}, then inverted on output: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Digit register value_q is updated only on edges where load=1. Between loads it holds, regardless of changes on value.
- Leading-zero suppression (blank_lz=1):
  - Digit i is blank when digits DIGITS-1 down to i are all zero and i > 0.
  - Digit 0 is never suppressed, so the value 0 shows as a single "0".
  - A nonzero digit stops suppression for all lower digits, so embedded zeros stay visible.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1 and wraps. blink_phase toggles on each wrap.
  - When blink_phase=0, a digit with its blink_mask bit set is blank.
  - Digits with blink_mask=0 are unaffected.
- Blank means 7'h7F on the output (all segments off). Priority: enable=0, then suppression or blink, then glyph.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On wrap, scan_idx advances idx → idx+1, and DIGITS-1 wraps to 0.
  - For exactly one cycle after each advance, scan_sel = all ones (anti-ghosting gap). Otherwise scan_sel has bit scan_idx low.
  - scan_seg always equals the segments slice for scan_idx.
  - With DIGITS=1, scan_idx stays 0 but the gap cycle still occurs on every wrap.
- Arithmetic: counters are $clog2 of their divider (minimum 1 bit) and compare against DIV-1. No overflow beyond the wrap value.

## Timing
- Reset values: value_q=0, segments and scan_seg all ones, scan_sel all ones, blink_cnt=0, blink_phase=1, scan_cnt=0, scan_idx=0.
- Reset asserted mid-operation forces these values immediately (asynchronous), independent of clk.
- All outputs are registered.
- load latency: with load sampled at edge N, value_q updates at edge N, and segments and scan_seg reflect the new value after edge N+1.
- enable, blank_lz and blink_mask: one-cycle latency to segments.
- load held high for consecutive cycles recaptures value on every edge; the last captured value wins.
- load coinciding with a blink toggle or scan advance: both take effect on the same edge, with no priority conflict.
- Blink period is 2*BLINK_DIV cycles. The first toggle to phase 0 happens at the BLINK_DIV-th edge after reset release.
- Scan dwell: each digit is selected for SCAN_DIV-1 cycles plus a 1-cycle gap, giving a full frame of DIGITS*SCAN_DIV cycles.

## Test plan
- Reset release, no load, blank_lz=0, enable=1 → after 1 edge every digit reads 7'h40 ("0"). During reset all outputs read all ones.
- DIGITS=6; load value=24'h00A0F1, blank_lz=1 → digits 5,4 = 7'h7F; digit 3 = 7'h08 (A); digit 2 = 7'h40 (0); digit 1 = 7'h0E (F); digit 0 = 7'h79 (1). Visible exactly 2 edges after load.
- Load 24'h000000 with blank_lz=1 → only digit 0 shows 7'h40, all others 7'h7F. Then enable=0 → all digits 7'h7F one cycle later.
- BLINK_DIV=4, blink_mask=6'b000001, value=5 → digit 0 alternates 7'h12 / 7'h7F every 4 cycles, starting visible. Other digits are steady.
- SCAN_DIV=3, DIGITS=4 → scan_sel sequence 1110, 1110, 1111, 1101, 1101, 1111, 1011, …, 0111, then wraps to 1110. scan_seg matches the selected digit slice.
- Assert reset mid-blink and mid-scan → outputs all ones immediately. After release, blink_phase=1 and scanning restarts at digit 0.

Source files
------------

// File: rtl/seven_segment_bank.sv
// Multi-digit hex display driver: latched digits, active-low glyphs, leading-zero
// suppression, per-digit blink and a scanned single-digit output with a gap cycle.
module seven_segment_bank #(
   parameter int DIGITS    = 6,
   parameter int BLINK_DIV = 25_000_000,
   parameter int SCAN_DIV  = 50_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic                  enable,
   input  logic                  blank_lz,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [7*DIGITS-1:0]   segments,
   output logic [6:0]            scan_seg,
   output logic [DIGITS-1:0]     scan_sel
);

   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   function automatic logic [6:0] hex_glyph(input logic [3:0] d);
      case (d)
         4'h0:    hex_glyph = 7'h3F;
         4'h1:    hex_glyph = 7'h06;
         4'h2:    hex_glyph = 7'h5B;
         4'h3:    hex_glyph = 7'h4F;
         4'h4:    hex_glyph = 7'h66;
         4'h5:    hex_glyph = 7'h6D;
         4'h6:    hex_glyph = 7'h7D;
         4'h7:    hex_glyph = 7'h07;
         4'h8:    hex_glyph = 7'h7F;
         4'h9:    hex_glyph = 7'h6F;
         4'hA:    hex_glyph = 7'h77;
         4'hB:    hex_glyph = 7'h7C;
         4'hC:    hex_glyph = 7'h39;
         4'hD:    hex_glyph = 7'h5E;
         4'hE:    hex_glyph = 7'h79;
         default: hex_glyph = 7'h71;
      endcase
   endfunction

   logic [4*DIGITS-1:0] r_value;
   logic [BW-1:0]       r_blink_cnt;
   logic                r_blink_phase;
   logic [SW-1:0]       r_scan_cnt;
   logic [IW-1:0]       r_scan_idx;

   logic [6:0]          w_dig [DIGITS];
   logic [7*DIGITS-1:0] w_seg_next;
   logic                w_blink_wrap;
   logic                w_scan_wrap;
   logic [IW-1:0]       w_idx_next;
   logic [DIGITS-1:0]   w_sel_next;

   assign w_blink_wrap = (r_blink_cnt == BLINK_MAX);
   assign w_scan_wrap  = (r_scan_cnt == SCAN_MAX);

   // Walk from the top digit down; suppression persists only while every higher digit is zero.
   always_comb begin
      logic v_zero;
      v_zero     = 1'b1;
      w_seg_next = '1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_zero = v_zero & (r_value[4*i +: 4] == 4'h0);
         if (!enable || (blank_lz && v_zero && (i > 0)) || (blink_mask[i] && !r_blink_phase))
            w_dig[i] = 7'h7F;
         else
            w_dig[i] = ~hex_glyph(r_value[4*i +: 4]);
         w_seg_next[7*i +: 7] = w_dig[i];
      end
   end

   always_comb begin
      w_idx_next = r_scan_idx;
      if (w_scan_wrap)
         w_idx_next = (r_scan_idx == IDX_MAX) ? '0 : r_scan_idx + 1'b1;
      w_sel_next = '1;
      if (!w_scan_wrap)
         w_sel_next[r_scan_idx] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_value       <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else begin
         if (load)
            r_value <= value;
         if (w_blink_wrap) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_scan_idx <= '0;
      end else begin
         r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
         r_scan_idx <= w_idx_next;
      end
   end

   // scan_seg follows the digit that scan_idx will point at after this edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         segments <= '1;
         scan_seg <= '1;
         scan_sel <= '1;
      end else begin
         segments <= w_seg_next;
         scan_seg <= w_dig[w_idx_next];
         scan_sel <= w_sel_next;
      end
   end

endmodule
